// File: rtl/lms_fir_mc.sv
// lms_fir_mc: multi-channel, time-multiplexed adaptive (LMS) FIR engine.
// Each channel has its own delay line and weight bank. A run processes one
// tap per clock. For each tap the weight is updated first, and the output
// multiply-accumulate then uses the updated weight.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start        run request, accepted only in IDLE with ch_sel < CH
//   clr_w        zero all weights of ch_sel (IDLE only, start=0)
//   ch_sel       channel for start / clr_w
//   x_in         new sample, shifted into the channel's delay line at start
//   a_in         accumulator preload (Q1.DW-1)
//   mu_err       step-scaled error, latched at start
//   adapt_en     weight update enable, latched at start
//   busy         high from the cycle after start through the output cycle
//   out_sample   saturated result, held until the next result
//   out_ch       channel tag of out_sample
//   out_valid    one-cycle result strobe
//   done         one-cycle completion strobe (same cycle as out_valid)
module lms_fir_mc #(
  parameter  int TAPS = 64,
  parameter  int DW   = 16,
  parameter  int WW   = 26,
  parameter  int CH   = 2,
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           clr_w,
  input  logic [CHW-1:0] ch_sel,
  input  logic [DW-1:0]  x_in,
  input  logic [DW-1:0]  a_in,
  input  logic [DW-1:0]  mu_err,
  input  logic           adapt_en,
  output logic           busy,
  output logic [DW-1:0]  out_sample,
  output logic [CHW-1:0] out_ch,
  output logic           out_valid,
  output logic           done
);

  localparam int KW   = $clog2(TAPS);
  localparam int ACCW = 2 * DW + KW + 1;
  // Weight-sum width: wide enough for both the weight and the full product.
  localparam int SW   = ((WW > 2 * DW) ? WW : 2 * DW) + 1;

  localparam logic signed [SW-1:0]   W_MAX = {{(SW - WW + 1){1'b0}}, {(WW - 1){1'b1}}};
  localparam logic signed [SW-1:0]   W_MIN = {{(SW - WW + 1){1'b1}}, {(WW - 1){1'b0}}};
  localparam logic signed [ACCW-1:0] O_MAX = {{(ACCW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [ACCW-1:0] O_MIN = {{(ACCW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                 state_q;
  logic [KW-1:0]          idx_q;
  logic                   drain_q;
  logic [CHW-1:0]         ch_q;
  logic signed [DW-1:0]   mu_q;
  logic                   adapt_q;

  logic signed [DW-1:0]   x_mem [CH][TAPS];
  logic signed [WW-1:0]   w_mem [CH][TAPS];

  // Pipeline: weight-update register -> product register -> accumulator.
  logic                   v1_q, v2_q;
  logic signed [DW-1:0]   wtop_q, xk_q;
  logic signed [2*DW-1:0] prod_q;
  logic signed [ACCW-1:0] acc_q;

  logic                   busy_q, out_valid_q, done_q;
  logic [DW-1:0]          out_sample_q;
  logic [CHW-1:0]         out_ch_q;

  logic                   ch_ok;
  logic signed [DW-1:0]   x_k;
  logic signed [WW-1:0]   w_k, w_new_d;
  logic signed [2*DW-1:0] p;
  logic signed [SW-1:0]   w_sum;
  logic signed [ACCW-1:0] acc_sum, acc_sh;
  logic signed [DW-1:0]   out_d;

  assign ch_ok = int'(ch_sel) < CH;

  // NOTE: every variable gets an unconditional default before the
  // saturation branches, so no path leaves it unassigned (no latch).
  always_comb begin
    x_k     = x_mem[ch_q][idx_q];
    w_k     = w_mem[ch_q][idx_q];
    p       = (2 * DW)'(mu_q) * (2 * DW)'(x_k);
    w_sum   = SW'(w_k) + SW'(p >>> (DW - 1));
    w_new_d = w_k;
    if (adapt_q) begin
      if (w_sum > W_MAX)      w_new_d = W_MAX[WW-1:0];
      else if (w_sum < W_MIN) w_new_d = W_MIN[WW-1:0];
      else                    w_new_d = w_sum[WW-1:0];
    end

    acc_sum = acc_q + ACCW'(prod_q);
    acc_sh  = acc_sum >>> (DW - 1);
    out_d   = acc_sh[DW-1:0];
    if (acc_sh > O_MAX)      out_d = O_MAX[DW-1:0];
    else if (acc_sh < O_MIN) out_d = O_MIN[DW-1:0];
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      drain_q      <= 1'b0;
      ch_q         <= '0;
      mu_q         <= '0;
      adapt_q      <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      wtop_q       <= '0;
      xk_q         <= '0;
      prod_q       <= '0;
      acc_q        <= '0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      out_sample_q <= '0;
      out_ch_q     <= '0;
      // NOTE: the delay lines and weight banks are flop arrays that must
      // come out of reset as zero, so they are cleared here explicitly.
      for (int c = 0; c < CH; c++) begin
        for (int i = 0; i < TAPS; i++) begin
          x_mem[c][i] <= '0;
          w_mem[c][i] <= '0;
        end
      end
    end else begin
      v1_q        <= 1'b0;
      v2_q        <= v1_q;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (v1_q) prod_q <= (2 * DW)'(wtop_q) * (2 * DW)'(xk_q);
      if (v2_q) acc_q  <= acc_sum;

      case (state_q)
        IDLE: begin
          if (start && ch_ok) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            ch_q    <= ch_sel;
            mu_q    <= $signed(mu_err);
            adapt_q <= adapt_en;
            acc_q   <= ACCW'($signed(a_in)) <<< (DW - 1);
            for (int i = TAPS - 1; i > 0; i--) x_mem[ch_sel][i] <= x_mem[ch_sel][i-1];
            x_mem[ch_sel][0] <= $signed(x_in);
          end else if (!start && clr_w && ch_ok) begin
            for (int i = 0; i < TAPS; i++) w_mem[ch_sel][i] <= '0;
          end
        end
        RUN: begin
          w_mem[ch_q][idx_q] <= w_new_d;
          wtop_q <= w_new_d[WW-1 -: DW];
          xk_q   <= x_k;
          v1_q   <= 1'b1;
          idx_q  <= idx_q + KW'(1);
          if (idx_q == KW'(TAPS - 1)) begin
            state_q <= DRAIN;
            drain_q <= 1'b0;
          end
        end
        DRAIN: begin
          drain_q <= 1'b1;
          // Second drain cycle: the last product is being accumulated now,
          // so the result is taken from acc_sum at this same edge.
          if (drain_q) begin
            state_q      <= OUT;
            out_valid_q  <= 1'b1;
            done_q       <= 1'b1;
            out_sample_q <= out_d;
            out_ch_q     <= ch_q;
          end
        end
        OUT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign out_sample = out_sample_q;
  assign out_ch     = out_ch_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;

endmodule

// File: doc/lms_fir_mc.md
# lms_fir_mc

Multi-channel, time-multiplexed adaptive (LMS) FIR engine; the parametrised successor to the single-channel 256-tap FIR. It keeps an independent delay line and weight bank per channel and processes one tap per clock. Each tap is a weight update followed immediately by the output multiply-accumulate using the updated weight. It sits between the sample controller and the output path, and it adds three features: per-run adaptation freeze, per-channel weight clear, and channel tagging of results.

## Interface
Parameters:
- TAPS, 64, taps per channel, power of two, ≥4
- DW, 16, sample/error width, Q1.(DW-1)
- WW, 26, weight width, ≥DW+1; the output multiply uses the weight's top DW bits
- CH, 2, channel count, ≥1; CHW = max(1, clog2(CH))

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  run request pulse, sampled only in IDLE
- clr_w  in  1  zero all weights of ch_sel, sampled only in IDLE
- ch_sel  in  CHW  channel for start/clr_w; values ≥CH ignore the request
- x_in  in  DW  new sample, shifted into the channel's delay line at start
- a_in  in  DW  accumulator preload
- mu_err  in  DW  step-scaled error for this run, latched at start
- adapt_en  in  1  1 = update weights this run, latched at start
- busy  out  1  high from cycle after start through output cycle
- out_sample  out  DW  saturated result
- out_ch  out  CHW  channel of out_sample
- out_valid  out  1  one-cycle result strobe
- done  out  1  one-cycle completion strobe, coincident with out_valid

## Operation
- FSM: IDLE -> RUN (TAPS cycles, index k = 0..TAPS-1) -> DRAIN (pipeline flush) -> OUT (1 cycle) -> IDLE.
- Start accepted (IDLE, start=1, ch_sel<CH):
  - latch ch, mu_err, adapt_en;
  - delay line of ch shifts: x[i] <= x[i-1], x[0] <= x_in;
  - acc <= sign-extended a_in <<< (DW-1).
- Tap k, weight stage:
  - p = mu_err*x[k] (2·DW signed);
  - inc = p >>> (DW-1), sign-extended;
  - w[k] <= sat_WW(w[k]+inc) if adapt_en, else w[k] unchanged.
- Tap k, MAC stage: acc += w_new[k][WW-1:WW-DW] * x[k], where w_new[k] is the updated value.
- Accumulator width ACCW = 2·DW + clog2(TAPS) + 1, which cannot overflow.
- Output: out_sample = sat_DW(acc >>> (DW-1)). Shifts truncate toward −∞.
- sat_N clamps to [−2^(N−1), 2^(N−1)−1].
- Other channels' delay lines and weights are never touched.
- clr_w accepted only in IDLE with start=0: zeroes w[0..TAPS-1] of ch_sel in one cycle. No busy, no done.
- start with clr_w in the same cycle: start wins and clr_w is dropped.
- start or clr_w while busy: ignored, no side effect.
- ch_sel ≥ CH: request ignored, FSM stays in IDLE.
- rst: FSM to IDLE; all weights, delay lines, acc and pipeline registers to 0; all outputs to 0. Applies mid-run too: that run is abandoned with no done.

## Timing
- Let cycle S be the edge that samples start=1.
- busy = 1 on cycles S+1 .. S+TAPS+3.
- out_valid = done = 1 for exactly cycle S+TAPS+3; busy falls the same cycle.
- The next start is accepted at the edge ending cycle S+TAPS+3 or later; back-to-back period is TAPS+4 cycles.
- out_sample and out_ch hold their values until the next OUT cycle or rst.
- Pipeline, one tap per cycle: read x[k] and w[k] -> weight update register -> product register -> accumulate. Total latency from the first read to the last accumulate is 3 cycles after the last read.
- Updated weights are visible to the next run of that channel.
- Reset values: busy=0, out_valid=0, done=0, out_sample=0, out_ch=0.

## Test plan
Defaults unless noted (TAPS=64, DW=16, WW=26, CH=2).
- Passthrough: after rst, start ch0, x_in=0x4000, a_in=0x0100, mu_err=0, adapt_en=0 -> out_sample=0x0100, out_ch=0. done/out_valid high only at S+67; busy high S+1..S+67.
- Adaptation: fresh ch0, x_in=0x4000, mu_err=0x7FFF, adapt_en=1, a_in=0 -> w0[0]=0x3FFF, out_sample=0x0007. Repeat with mu_err=0, adapt_en=0, x_in=0x4000 -> out_sample=0x0007 and w0 unchanged.
- Channel isolation: after the adaptation run, start ch1 with x_in=0x4000, a_in=0x1234, mu_err=0 -> out_sample=0x1234, out_ch=1. Rerun ch0 as above -> still 0x0007.
- Saturation:
  - a_in=0x7FFF plus positive MAC -> out_sample=0x7FFF; a_in=0x8000 plus negative MAC -> 0x8000.
  - 1000 runs with x_in=0x7FFF, mu_err=0x7FFF -> w0[0] pins at 2^25−1 and never wraps.
- Control corners:
  - start at S+10 while busy -> ignored, one done only.
  - start+clr_w same cycle -> run executes, weights kept.
  - clr_w ch0 in IDLE -> next ch0 passthrough run gives out_sample=a_in.
  - ch_sel=2 with CH=2 -> no busy.
- Reset mid-run: rst at S+20 -> no done, outputs 0. A following fresh run matches the first scenario bit-exactly.
